// File: rtl/pipeline_types.sv
// Shared types for the pipeline memory arbiter: FSM encoding, latched
// request record and timeout counter width.
package pipeline_types;

   localparam int TIMEOUT_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUS_IF = 2'd1,
      BUS_ME = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        we;
   } mem_req_t;

   // Fetches are always full-word reads.
   function automatic mem_req_t fetchReq(input logic [31:0] addr);
      mem_req_t r;
      r.addr  = addr;
      r.wdata = 32'h0;
      r.be    = 4'hF;
      r.we    = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side request/response and shared memory port signals of the arbiter.
// slave = arbiter side, master = pipeline/memory side.
interface mem_arbiter_if;

   logic        iIF_req;
   logic [31:0] iIF_addr;
   logic        iME_req;
   logic        iME_we;
   logic [3:0]  iME_be;
   logic [31:0] iME_addr;
   logic [31:0] iME_wdata;
   logic [31:0] oIF_data;
   logic [31:0] oME_rdata;
   logic        oIF_valid;
   logic        oME_valid;
   logic        oStall_IF;
   logic        oStall_ME;
   logic        oBus_req;
   logic        oBus_we;
   logic [3:0]  oBus_be;
   logic [31:0] oBus_addr;
   logic [31:0] oBus_wdata;
   logic        iBus_ack;
   logic [31:0] iBus_rdata;
   logic        oErr;
   logic        oErr_src;

   modport slave (
      input  iIF_req, iIF_addr, iME_req, iME_we, iME_be, iME_addr, iME_wdata,
      input  iBus_ack, iBus_rdata,
      output oIF_data, oME_rdata, oIF_valid, oME_valid, oStall_IF, oStall_ME,
      output oBus_req, oBus_we, oBus_be, oBus_addr, oBus_wdata, oErr, oErr_src
   );

   modport master (
      output iIF_req, iIF_addr, iME_req, iME_we, iME_be, iME_addr, iME_wdata,
      output iBus_ack, iBus_rdata,
      input  oIF_data, oME_rdata, oIF_valid, oME_valid, oStall_IF, oStall_ME,
      input  oBus_req, oBus_we, oBus_be, oBus_addr, oBus_wdata, oErr, oErr_src
   );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates IF fetches and ME loads/stores onto one memory port, ME first,
// with a bus-wait timeout that aborts the transaction and flags an error.
//
// state  | meaning
// IDLE   | no transaction; pick ME over IF, latch winner's request
// BUS_IF | fetch on the bus, waiting for ack or timeout
// BUS_ME | ME access on the bus, waiting for ack or timeout
// RESP   | one-cycle valid (and error) pulse; requests ignored
module mem_arbiter
   import pipeline_types::*;
#(
   parameter logic [TIMEOUT_W-1:0] TIMEOUT = 8'd255
) (
   input logic         iClk,
   input logic         nRst,
   mem_arbiter_if.slave bus
);

   arb_state_t           state;
   mem_req_t             reqLat;
   logic [TIMEOUT_W-1:0] waitCnt;
   logic                 busReq;
   logic                 ifValid;
   logic                 meValid;
   logic [31:0]          ifData;
   logic [31:0]          meData;
   logic                 err;
   logic                 errSrc;

   always_ff @(posedge iClk) begin
      if (!nRst) begin
         state   <= IDLE;
         reqLat  <= '0;
         waitCnt <= '0;
         busReq  <= 1'b0;
         ifValid <= 1'b0;
         meValid <= 1'b0;
         ifData  <= 32'h0;
         meData  <= 32'h0;
         err     <= 1'b0;
         errSrc  <= 1'b0;
      end else begin
         ifValid <= 1'b0;
         meValid <= 1'b0;
         err     <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.iME_req) begin
                  reqLat  <= '{addr: bus.iME_addr, wdata: bus.iME_wdata,
                               be: bus.iME_be, we: bus.iME_we};
                  waitCnt <= '0;
                  busReq  <= 1'b1;
                  state   <= BUS_ME;
               end else if (bus.iIF_req) begin
                  reqLat  <= fetchReq(bus.iIF_addr);
                  waitCnt <= '0;
                  busReq  <= 1'b1;
                  state   <= BUS_IF;
               end
            end
            BUS_IF, BUS_ME: begin
               // An ack in the timeout cycle still counts as a normal completion.
               if (bus.iBus_ack || waitCnt == TIMEOUT) begin
                  if (state == BUS_ME) begin
                     meData  <= bus.iBus_ack ? bus.iBus_rdata : 32'h0;
                     meValid <= 1'b1;
                  end else begin
                     ifData  <= bus.iBus_ack ? bus.iBus_rdata : 32'h0;
                     ifValid <= 1'b1;
                  end
                  if (!bus.iBus_ack) begin
                     err    <= 1'b1;
                     errSrc <= (state == BUS_ME);
                  end
                  busReq <= 1'b0;
                  state  <= RESP;
               end else begin
                  waitCnt <= waitCnt + 1'b1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.oBus_req   = busReq;
   assign bus.oBus_we    = reqLat.we;
   assign bus.oBus_be    = reqLat.be;
   assign bus.oBus_addr  = reqLat.addr;
   assign bus.oBus_wdata = reqLat.wdata;
   assign bus.oIF_valid  = ifValid;
   assign bus.oME_valid  = meValid;
   assign bus.oIF_data   = ifData;
   assign bus.oME_rdata  = meData;
   assign bus.oErr       = err;
   assign bus.oErr_src   = errSrc;

   // Stall drops in the valid cycle so the pipe advances with the data.
   assign bus.oStall_IF  = bus.iIF_req & ~ifValid;
   assign bus.oStall_ME  = bus.iME_req & ~meValid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with TIMEOUT = 4.
module tb_mem_arbiter;

   logic clk;
   logic nRst;
   int   tests;
   int   fails;

   mem_arbiter_if bus ();

   mem_arbiter #(.TIMEOUT(8'd4)) dut (
      .iClk(clk),
      .nRst(nRst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clearInputs();
      bus.iIF_req    = 1'b0;
      bus.iIF_addr   = 32'h0;
      bus.iME_req    = 1'b0;
      bus.iME_we     = 1'b0;
      bus.iME_be     = 4'h0;
      bus.iME_addr   = 32'h0;
      bus.iME_wdata  = 32'h0;
      bus.iBus_ack   = 1'b0;
      bus.iBus_rdata = 32'h0;
   endtask

   task automatic test_reset();
      nRst = 1'b0;
      clearInputs();
      tick(); tick();
      tests++; if (bus.oBus_req !== 1'b0) begin fails++; $display("FAIL reset_bus_req got %b want 0", bus.oBus_req); end
      tests++; if (bus.oBus_addr !== 32'h0) begin fails++; $display("FAIL reset_bus_addr got %h want 0", bus.oBus_addr); end
      tests++; if (bus.oBus_be !== 4'h0) begin fails++; $display("FAIL reset_bus_be got %h want 0", bus.oBus_be); end
      tests++; if ({bus.oIF_valid, bus.oME_valid, bus.oErr, bus.oErr_src} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b want 0000", {bus.oIF_valid, bus.oME_valid, bus.oErr, bus.oErr_src}); end
      tests++; if ({bus.oIF_data, bus.oME_rdata} !== 64'h0) begin fails++; $display("FAIL reset_data got %h want 0", {bus.oIF_data, bus.oME_rdata}); end
      bus.iIF_req = 1'b1;
      #1;
      tests++; if (bus.oStall_IF !== 1'b1) begin fails++; $display("FAIL reset_stall_follow got %b want 1", bus.oStall_IF); end
      bus.iIF_req = 1'b0;
      nRst = 1'b1;
      tick();
   endtask

   task automatic test_if_fetch();
      bus.iIF_req  = 1'b1;
      bus.iIF_addr = 32'h100;
      tick();
      tests++; if (bus.oBus_req !== 1'b1) begin fails++; $display("FAIL fetch_bus_req got %b want 1", bus.oBus_req); end
      tests++; if ({bus.oBus_addr, bus.oBus_be, bus.oBus_we} !== {32'h100, 4'hF, 1'b0}) begin fails++; $display("FAIL fetch_bus_fields got %h/%h/%b want 100/f/0", bus.oBus_addr, bus.oBus_be, bus.oBus_we); end
      tests++; if (bus.oStall_IF !== 1'b1) begin fails++; $display("FAIL fetch_stall_wait got %b want 1", bus.oStall_IF); end
      tick();
      tests++; if (bus.oBus_req !== 1'b1 || bus.oBus_addr !== 32'h100 || bus.oIF_valid !== 1'b0) begin fails++; $display("FAIL fetch_hold got req=%b addr=%h valid=%b want 1/100/0", bus.oBus_req, bus.oBus_addr, bus.oIF_valid); end
      bus.iBus_ack   = 1'b1;
      bus.iBus_rdata = 32'hDEADBEEF;
      tick();
      tests++; if (bus.oIF_valid !== 1'b1 || bus.oIF_data !== 32'hDEADBEEF) begin fails++; $display("FAIL fetch_valid got %b/%h want 1/deadbeef", bus.oIF_valid, bus.oIF_data); end
      tests++; if (bus.oStall_IF !== 1'b0 || bus.oBus_req !== 1'b0 || bus.oErr !== 1'b0) begin fails++; $display("FAIL fetch_resp got stall=%b req=%b err=%b want 0/0/0", bus.oStall_IF, bus.oBus_req, bus.oErr); end
      bus.iIF_req  = 1'b0;
      bus.iBus_ack = 1'b0;
      bus.iBus_rdata = 32'h0;
      tick();
      tests++; if (bus.oIF_valid !== 1'b0 || bus.oIF_data !== 32'hDEADBEEF) begin fails++; $display("FAIL fetch_after got %b/%h want 0/deadbeef", bus.oIF_valid, bus.oIF_data); end
   endtask

   task automatic test_priority();
      bus.iIF_req   = 1'b1;
      bus.iIF_addr  = 32'h300;
      bus.iME_req   = 1'b1;
      bus.iME_we    = 1'b1;
      bus.iME_be    = 4'b0011;
      bus.iME_addr  = 32'h200;
      bus.iME_wdata = 32'h12345678;
      tick();
      tests++; if ({bus.oBus_req, bus.oBus_we, bus.oBus_be, bus.oBus_addr, bus.oBus_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h200, 32'h12345678}) begin fails++; $display("FAIL prio_me_bus got %b/%b/%h/%h/%h want 1/1/3/200/12345678", bus.oBus_req, bus.oBus_we, bus.oBus_be, bus.oBus_addr, bus.oBus_wdata); end
      tests++; if ({bus.oStall_IF, bus.oStall_ME} !== 2'b11) begin fails++; $display("FAIL prio_stalls got %b want 11", {bus.oStall_IF, bus.oStall_ME}); end
      bus.iBus_ack = 1'b1;
      tick();
      tests++; if ({bus.oME_valid, bus.oIF_valid, bus.oStall_ME, bus.oStall_IF} !== 4'b1001) begin fails++; $display("FAIL prio_me_resp got %b want 1001", {bus.oME_valid, bus.oIF_valid, bus.oStall_ME, bus.oStall_IF}); end
      bus.iME_req  = 1'b0;
      bus.iME_we   = 1'b0;
      bus.iBus_ack = 1'b0;
      tick();
      tests++; if (bus.oBus_req !== 1'b0 || bus.oIF_valid !== 1'b0) begin fails++; $display("FAIL prio_idle got req=%b ifv=%b want 0/0", bus.oBus_req, bus.oIF_valid); end
      tick();
      tests++; if ({bus.oBus_req, bus.oBus_we, bus.oBus_be, bus.oBus_addr, bus.oBus_wdata} !== {1'b1, 1'b0, 4'hF, 32'h300, 32'h0}) begin fails++; $display("FAIL prio_if_bus got %b/%b/%h/%h/%h want 1/0/f/300/0", bus.oBus_req, bus.oBus_we, bus.oBus_be, bus.oBus_addr, bus.oBus_wdata); end
      bus.iBus_ack   = 1'b1;
      bus.iBus_rdata = 32'hCAFEF00D;
      tick();
      tests++; if (bus.oIF_valid !== 1'b1 || bus.oIF_data !== 32'hCAFEF00D || bus.oME_valid !== 1'b0) begin fails++; $display("FAIL prio_if_resp got %b/%h/%b want 1/cafef00d/0", bus.oIF_valid, bus.oIF_data, bus.oME_valid); end
      clearInputs();
      tick();
   endtask

   task automatic test_back_to_back();
      bus.iME_req  = 1'b1;
      bus.iME_addr = 32'h500;
      tick();
      for (int k = 0; k < 3; k++) begin
         tests++; if (bus.oBus_req !== 1'b1 || bus.oBus_addr !== 32'h500 + 32'(4 * k) || bus.oBus_we !== 1'b0) begin fails++; $display("FAIL b2b_bus[%0d] got %b/%h/%b want 1/%h/0", k, bus.oBus_req, bus.oBus_addr, bus.oBus_we, 32'h500 + 32'(4 * k)); end
         bus.iBus_ack   = 1'b1;
         bus.iBus_rdata = 32'h10000001 + 32'(k);
         tick();
         tests++; if (bus.oME_valid !== 1'b1 || bus.oME_rdata !== 32'h10000001 + 32'(k) || bus.oBus_req !== 1'b0) begin fails++; $display("FAIL b2b_resp[%0d] got %b/%h/%b want 1/%h/0", k, bus.oME_valid, bus.oME_rdata, bus.oBus_req, 32'h10000001 + 32'(k)); end
         bus.iBus_ack = 1'b0;
         if (k < 2) bus.iME_addr = 32'h500 + 32'(4 * (k + 1));
         else       bus.iME_req = 1'b0;
         tick();
         tests++; if (bus.oME_valid !== 1'b0 || bus.oBus_req !== 1'b0) begin fails++; $display("FAIL b2b_idle[%0d] got %b/%b want 0/0", k, bus.oME_valid, bus.oBus_req); end
         tick();
      end
      clearInputs();
   endtask

   task automatic test_timeout();
      bus.iME_req    = 1'b1;
      bus.iME_addr   = 32'h400;
      bus.iBus_rdata = 32'hFFFFFFFF;
      for (int i = 1; i <= 5; i++) begin
         tick();
         tests++; if (bus.oBus_req !== 1'b1 || bus.oErr !== 1'b0 || bus.oME_valid !== 1'b0) begin fails++; $display("FAIL tmo_wait[%0d] got %b/%b/%b want 1/0/0", i, bus.oBus_req, bus.oErr, bus.oME_valid); end
      end
      tick();
      tests++; if ({bus.oErr, bus.oErr_src, bus.oME_valid} !== 3'b111 || bus.oME_rdata !== 32'h0) begin fails++; $display("FAIL tmo_me got err=%b src=%b v=%b d=%h want 1/1/1/0", bus.oErr, bus.oErr_src, bus.oME_valid, bus.oME_rdata); end
      bus.iME_req = 1'b0;
      tick();
      tests++; if (bus.oErr !== 1'b0 || bus.oME_valid !== 1'b0) begin fails++; $display("FAIL tmo_pulse got %b/%b want 0/0", bus.oErr, bus.oME_valid); end
      // IF-side abort: the error source must point at the fetch
      bus.iIF_req  = 1'b1;
      bus.iIF_addr = 32'h600;
      for (int i = 1; i <= 5; i++) tick();
      tests++; if (bus.oBus_req !== 1'b1 || bus.oErr !== 1'b0) begin fails++; $display("FAIL tmo_if_wait got %b/%b want 1/0", bus.oBus_req, bus.oErr); end
      tick();
      tests++; if ({bus.oErr, bus.oErr_src, bus.oIF_valid} !== 3'b101 || bus.oIF_data !== 32'h0) begin fails++; $display("FAIL tmo_if got err=%b src=%b v=%b d=%h want 1/0/1/0", bus.oErr, bus.oErr_src, bus.oIF_valid, bus.oIF_data); end
      clearInputs();
      tick();
   endtask

   task automatic test_ack_at_timeout();
      bus.iIF_req  = 1'b1;
      bus.iIF_addr = 32'h700;
      for (int i = 1; i <= 5; i++) tick();
      bus.iBus_ack   = 1'b1;
      bus.iBus_rdata = 32'h5555AAAA;
      tick();
      tests++; if (bus.oIF_valid !== 1'b1 || bus.oIF_data !== 32'h5555AAAA || bus.oErr !== 1'b0) begin fails++; $display("FAIL ack_tmo got v=%b d=%h err=%b want 1/5555aaaa/0", bus.oIF_valid, bus.oIF_data, bus.oErr); end
      clearInputs();
      tick();
   endtask

   task automatic test_reset_mid();
      bus.iIF_req  = 1'b1;
      bus.iIF_addr = 32'h800;
      tick();
      tests++; if (bus.oBus_req !== 1'b1) begin fails++; $display("FAIL rstmid_busy got %b want 1", bus.oBus_req); end
      nRst = 1'b0;
      tick();
      tests++; if ({bus.oBus_req, bus.oIF_valid, bus.oErr} !== 3'b000 || bus.oIF_data !== 32'h0) begin fails++; $display("FAIL rstmid_drop got %b d=%h want 000/0", {bus.oBus_req, bus.oIF_valid, bus.oErr}, bus.oIF_data); end
      tests++; if (bus.oStall_IF !== 1'b1) begin fails++; $display("FAIL rstmid_stall got %b want 1", bus.oStall_IF); end
      nRst = 1'b1;
      bus.iIF_req = 1'b0;
      tick();
      tests++; if (bus.oBus_req !== 1'b0 || bus.oIF_valid !== 1'b0) begin fails++; $display("FAIL rstmid_idle got %b/%b want 0/0", bus.oBus_req, bus.oIF_valid); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_if_fetch();
      test_priority();
      test_back_to_back();
      test_timeout();
      test_ack_at_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
